// File: rtl/csr_access_unit.sv
// csr_access_unit
// Initiator side of the CSR register-file port. Runs one Zicsr instruction
// (CSRRW/CSRRS/CSRRC and their immediate forms) as a read-modify-write
// sequence for the execute stage. It returns the pre-write CSR value, or
// reports the access as illegal.
module csr_access_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    // Request from the execute stage
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_src,
    input  logic            req_src_nz,
    input  logic            flush,

    // Response back to the pipeline
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_illegal,

    // Port to the CSRs block
    output logic            csr_w,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_din,
    input  logic [XLEN-1:0] csr_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_WRITE,
        OP_SET,
        OP_CLEAR
    } op_t;

    state_t          state_q,  state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [11:0]     addr_q,   addr_d;
    logic [XLEN-1:0] src_q,    src_d;
    logic            src_nz_q, src_nz_d;
    logic [XLEN-1:0] din_q,    din_d;
    logic [XLEN-1:0] rdata_q,  rdata_d;
    logic            illegal_q, illegal_d;

    op_t             op;
    logic            implemented;
    logic            read_only;
    logic            write_req;
    logic            access_illegal;
    logic [XLEN-1:0] new_val;

    // Decode the latched instruction: operation kind, legality and new value
    always_comb begin
        op             = OP_NONE;
        implemented    = 1'b0;
        read_only      = (addr_q[11:10] == 2'b11);
        write_req      = 1'b0;
        access_illegal = 1'b0;
        new_val        = src_q;

        // Immediate forms share the operation of their register forms;
        // funct3 000 and 100 are not CSR operations.
        case (funct3_q)
            3'b001, 3'b101: op = OP_WRITE;
            3'b010, 3'b110: op = OP_SET;
            3'b011, 3'b111: op = OP_CLEAR;
            default:        op = OP_NONE;
        endcase

        case (addr_q)
            12'hF11, 12'hF12, 12'hF13, 12'hF14,
            12'h300, 12'h301, 12'h304, 12'h305,
            12'h340, 12'h341, 12'h342, 12'h343, 12'h344:
                implemented = 1'b1;
            default:
                implemented = 1'b0;
        endcase

        // Set/clear with a zero source field is a pure read, so it is legal
        // even on read-only CSRs.
        write_req = (op == OP_WRITE) || ((op != OP_NONE) && src_nz_q);

        access_illegal = (op == OP_NONE) || !implemented || (write_req && read_only);

        case (op)
            OP_WRITE: new_val = src_q;
            OP_SET:   new_val = csr_dout | src_q;
            OP_CLEAR: new_val = csr_dout & ~src_q;
            default:  new_val = csr_dout;
        endcase
    end

    // Next-state and datapath register updates for the read-modify-write sequence
    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        src_d     = src_q;
        src_nz_d  = src_nz_q;
        din_d     = din_q;
        rdata_d   = rdata_q;
        illegal_d = illegal_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    src_d    = req_src;
                    src_nz_d = req_src_nz;
                    state_d  = S_READ;
                end
            end

            S_READ: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (access_illegal) begin
                    illegal_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = S_RESP;
                end else if (write_req) begin
                    illegal_d = 1'b0;
                    rdata_d   = csr_dout;
                    din_d     = new_val;
                    state_d   = S_WRITE;
                end else begin
                    illegal_d = 1'b0;
                    rdata_d   = csr_dout;
                    state_d   = S_RESP;
                end
            end

            S_WRITE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                if (flush || rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything the outside world sees
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            funct3_q  <= '0;
            addr_q    <= '0;
            src_q     <= '0;
            src_nz_q  <= 1'b0;
            din_q     <= '0;
            rdata_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            src_q     <= src_d;
            src_nz_q  <= src_nz_d;
            din_q     <= din_d;
            rdata_q   <= rdata_d;
            illegal_q <= illegal_d;
        end
    end

    // Handshakes and strobes decoded from state; flush kills the write and the response at once
    always_comb begin
        req_ready   = (state_q == S_IDLE)  && !rst && !flush;
        csr_w       = (state_q == S_WRITE) && !rst && !flush;
        rsp_valid   = (state_q == S_RESP)  && !rst && !flush;
        csr_addr    = addr_q;
        csr_din     = din_q;
        rsp_rdata   = rdata_q;
        rsp_illegal = illegal_q;
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit
// Randomised scoreboard bench for csr_access_unit. A behavioural CSR file
// answers the unit's read port, and a reference model predicts every write
// and response. A monitor pops the expectations whenever the DUT strobes csr_w
// or completes a response handshake.
module tb_csr_access_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [11:0]     req_addr;
    logic [XLEN-1:0] req_src;
    logic            req_src_nz;
    logic            flush;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_illegal;
    logic            csr_w;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_din;
    logic [XLEN-1:0] csr_dout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [XLEN-1:0] rdata;
        logic            illegal;
    } rsp_t;

    typedef struct {
        logic [11:0]     addr;
        logic [XLEN-1:0] data;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    // Environment CSR file and the model's private copy of it
    logic [XLEN-1:0] env_mem [0:4095];
    logic [XLEN-1:0] ref_csr [0:4095];
    logic            preload;

    logic [11:0] impl_list [0:12];

    csr_access_unit #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_src     (req_src),
        .req_src_nz  (req_src_nz),
        .flush       (flush),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_illegal (rsp_illegal),
        .csr_w       (csr_w),
        .csr_addr    (csr_addr),
        .csr_din     (csr_din),
        .csr_dout    (csr_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] init_val(input int idx);
        case (idx)
            'hF11:   return 32'h0000_0489;
            'hF12:   return 32'h8000_0015;
            'hF13:   return 32'h0001_0203;
            default: return '0;
        endcase
    endfunction

    // Behavioural CSR file: combinational read, write on the strobe
    assign csr_dout = env_mem[csr_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) env_mem[i] <= init_val(i);
        end else if (csr_w) begin
            env_mem[csr_addr] <= csr_din;
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic logic is_impl(input logic [11:0] a);
        return a inside {12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h300, 12'h301, 12'h304,
                         12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344};
    endfunction

    // Reference model: Zicsr read-modify-write rules on the model's CSR copy
    task automatic model_eval(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] s,
                              input logic nz, output logic ill, output logic wreq,
                              output logic [31:0] old, output logic [31:0] nv);
        logic [1:0] kind;
        kind = f3[1:0];
        old  = ref_csr[a];
        wreq = (kind == 2'b01) || nz;
        ill  = (kind == 2'b00) || !is_impl(a) || (wreq && (a[11:10] == 2'b11));
        case (kind)
            2'b01:   nv = s;
            2'b10:   nv = old | s;
            2'b11:   nv = old & ~s;
            default: nv = old;
        endcase
    endtask

    // Monitor: pops the scoreboard on every write strobe and response handshake
    always @(negedge clk) begin
        wr_t  w;
        rsp_t r;
        if (!rst) begin
            if (csr_w) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_csr_w", {31'd0, csr_w}, 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    check("csr_addr", {20'd0, csr_addr}, {20'd0, w.addr});
                    check("csr_din", csr_din, w.data);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, r.rdata);
                    check("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, r.illegal});
                end
            end
        end
    end

    // Outputs that must all be zero during/after reset
    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"},   {31'd0, rsp_valid},   32'd0);
        check({tag, "_rsp_rdata"},   rsp_rdata,            32'd0);
        check({tag, "_rsp_illegal"}, {31'd0, rsp_illegal}, 32'd0);
        check({tag, "_csr_w"},       {31'd0, csr_w},       32'd0);
        check({tag, "_csr_addr"},    {20'd0, csr_addr},    32'd0);
        check({tag, "_csr_din"},     csr_din,              32'd0);
        check({tag, "_req_ready"},   {31'd0, req_ready},   32'd0);
    endtask

    // One instruction. stage: 0 normal, 1 flush in READ, 2 flush in WRITE,
    // 3 flush in RESP, 4 reset in READ. Called and returns at posedge+1 with the unit idle.
    task automatic apply_stimulus(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] s,
                                  input logic nz, input int stage_in, input int delay);
        logic        ill, wreq, wpath;
        logic [31:0] old, nv, exp_rdata;
        int          stage;
        rsp_t        r;
        wr_t         w;

        stage = stage_in;
        model_eval(f3, a, s, nz, ill, wreq, old, nv);
        wpath     = !ill && wreq;
        exp_rdata = ill ? 32'd0 : old;
        if (stage == 2 && !wpath) stage = 3;

        if (wpath && (stage == 0 || stage == 3)) begin
            w.addr = a;
            w.data = nv;
            wr_q.push_back(w);
            ref_csr[a] = nv;
        end
        if (stage == 0) begin
            r.rdata   = exp_rdata;
            r.illegal = ill;
            rsp_q.push_back(r);
        end

        req_valid  = 1'b1;
        req_funct3 = f3;
        req_addr   = a;
        req_src    = s;
        req_src_nz = nz;
        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_funct3 = 3'($urandom);
        req_addr   = 12'($urandom);
        req_src    = $urandom;
        req_src_nz = 1'($urandom);

        if (stage == 1) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            return;
        end
        if (stage == 4) begin
            rst = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            check_reset_outputs("rst_mid_read");
            rst = 1'b0;
            @(posedge clk); #1;
            return;
        end

        @(posedge clk); #1;
        if (wpath) begin
            if (stage == 2) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end

        if (stage == 3) begin
            flush = 1'b1;
            @(negedge clk);
            check("flush_resp_valid", {31'd0, rsp_valid}, 32'd0);
            @(posedge clk); #1;
            flush = 1'b0;
            return;
        end

        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_rsp_rdata", rsp_rdata, exp_rdata);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        check("latency_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]  f3;
        logic [11:0] a;
        logic [31:0] s;
        logic        nz;
        int          stage;
        int          pick;

        impl_list = '{12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h300, 12'h301, 12'h304,
                      12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344};
        for (int i = 0; i < 4096; i++) ref_csr[i] = init_val(i);

        rst        = 1'b1;
        preload    = 1'b1;
        req_valid  = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_src    = '0;
        req_src_nz = 1'b0;
        flush      = 1'b0;
        rsp_ready  = 1'b0;
        @(posedge clk); #1;
        preload = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // CSRRW mscratch, then read it back
        apply_stimulus(3'b001, 12'h340, 32'hDEAD_BEEF, 1'b1, 0, 0);
        check("mscratch_after_rw", env_mem[12'h340], 32'hDEAD_BEEF);
        apply_stimulus(3'b010, 12'h340, 32'h0, 1'b0, 0, 0);

        // Set then clear bits
        apply_stimulus(3'b001, 12'h340, 32'h0000_000F, 1'b1, 0, 0);
        apply_stimulus(3'b010, 12'h340, 32'h0000_00F0, 1'b1, 0, 0);
        apply_stimulus(3'b011, 12'h340, 32'h0000_000F, 1'b1, 0, 0);
        check("mscratch_after_rc", env_mem[12'h340], 32'h0000_00F0);

        // Read-only space: pure read is legal, write is illegal
        apply_stimulus(3'b110, 12'hF14, 32'h0, 1'b0, 0, 0);
        apply_stimulus(3'b010, 12'hF11, 32'h0, 1'b0, 0, 0);
        apply_stimulus(3'b001, 12'hF14, 32'h0000_0123, 1'b1, 0, 0);

        // Bad funct3 and unimplemented address
        apply_stimulus(3'b100, 12'h340, 32'h5, 1'b1, 0, 0);
        apply_stimulus(3'b000, 12'h300, 32'h5, 1'b1, 0, 0);
        apply_stimulus(3'b001, 12'h7C0, 32'h1, 1'b1, 0, 0);

        // Consumer stalls for five cycles
        apply_stimulus(3'b001, 12'h341, 32'h8000_0004, 1'b1, 0, 5);

        // Flush in WRITE leaves mscratch untouched
        apply_stimulus(3'b001, 12'h340, 32'h1234_5678, 1'b1, 2, 0);
        repeat (2) @(posedge clk);
        #1;
        check("mscratch_after_flush", env_mem[12'h340], 32'h0000_00F0);

        // Flush in READ, flush in RESP after the write has landed
        apply_stimulus(3'b001, 12'h340, 32'hFFFF_FFFF, 1'b1, 1, 0);
        apply_stimulus(3'b010, 12'h340, 32'h0000_0100, 1'b1, 3, 0);

        // Flush while idle blocks acceptance
        req_valid  = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 12'h340;
        req_src    = 32'hAAAA_AAAA;
        req_src_nz = 1'b1;
        flush      = 1'b1;
        @(negedge clk);
        check("idle_flush_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;

        // Reset in READ, then confirm mscratch still holds 0x1F0
        apply_stimulus(3'b001, 12'h340, 32'h0, 1'b1, 4, 0);
        apply_stimulus(3'b010, 12'h340, 32'h0, 1'b0, 0, 0);
        check("mscratch_final_directed", env_mem[12'h340], 32'h0000_01F0);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            f3   = 3'($urandom_range(0, 7));
            pick = $urandom_range(0, 9);
            if (pick < 8) a = impl_list[$urandom_range(0, 12)];
            else          a = 12'($urandom);
            if (f3[2]) begin
                s  = 32'($urandom_range(0, 31));
                nz = (s != 0);
            end else begin
                s  = $urandom;
                nz = ($urandom_range(0, 3) != 0);
            end
            pick = $urandom_range(0, 19);
            if (pick < 4) stage = pick + 1;
            else          stage = 0;
            apply_stimulus(f3, a, s, nz, stage, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rsp_queue_drained", rsp_q.size(), 32'd0);
        check("wr_queue_drained", wr_q.size(), 32'd0);
        check("mscratch_model", env_mem[12'h340], ref_csr[12'h340]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
